// File: rtl/aes32_dec_1p_if.sv
// rtl/aes32_dec_1p_if.sv - request, key-RAM and result signals of the AES-128 column decryptor
interface aes32_dec_1p_if;
    logic        start;
    logic [31:0] din;
    logic [31:0] key;
    logic [5:0]  key_addr;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    modport master (
        output start, din, key,
        input  key_addr, busy, done, dout
    );

    modport slave (
        input  start, din, key,
        output key_addr, busy, done, dout
    );
endinterface

// File: rtl/aes32_dec_1p.sv
// rtl/aes32_dec_1p.sv - AES-128 decryption, one 32-bit column per cycle, one block in flight
module aes32_dec_1p (
    input  logic          clk,
    input  logic          rst_n,
    aes32_dec_1p_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUT} fsm_t;

    // Inverse S-box, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Offset of entry b is (255-b)*8, i.e. {~b, 3'b000}.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a [0:3];
        logic [7:0] m9 [0:3];
        logic [7:0] mb [0:3];
        logic [7:0] md [0:3];
        logic [7:0] me [0:3];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    fsm_t        fsm, fsm_n;
    logic [1:0]  col, col_n;
    logic [3:0]  rnd, rnd_n;
    logic [5:0]  key_addr, key_addr_n;
    logic        done, done_n;
    logic [31:0] dout, dout_n;
    logic [31:0] state  [0:3];
    logic [31:0] shadow [0:3];
    logic        wr_en;
    logic        shadow_ld;
    logic [31:0] wr_word;
    logic [1:0]  c1, c2, c3;
    logic [31:0] isb_col, ark_col, imc_col;

    // Row r of the output column comes from shadow column col-r (InvShiftRows).
    assign c1      = col - 2'd1;
    assign c2      = col - 2'd2;
    assign c3      = col - 2'd3;
    assign isb_col = {inv_sbox(shadow[col][31:24]), inv_sbox(shadow[c1][23:16]),
                      inv_sbox(shadow[c2][15:8]),   inv_sbox(shadow[c3][7:0])};
    assign ark_col = isb_col ^ bus.key;
    assign imc_col = inv_mix_col(ark_col);

    // Next-state, column write and registered-output selection.
    always_comb begin
        fsm_n      = fsm;
        col_n      = col;
        rnd_n      = rnd;
        wr_en      = 1'b0;
        shadow_ld  = 1'b0;
        wr_word    = bus.din ^ bus.key;
        done_n     = 1'b0;
        dout_n     = 32'd0;
        key_addr_n = 6'd40;
        case (fsm)
            IDLE: begin
                col_n = 2'd0;
                if (bus.start) begin
                    wr_en = 1'b1;
                    col_n = 2'd1;
                    fsm_n = LOAD;
                end
            end
            LOAD: begin
                wr_en = 1'b1;
                col_n = col + 2'd1;
                if (col == 2'd3) begin
                    shadow_ld = 1'b1;
                    rnd_n     = 4'd9;
                    fsm_n     = ROUND;
                end
            end
            ROUND: begin
                wr_en   = 1'b1;
                wr_word = imc_col;
                col_n   = col + 2'd1;
                if (col == 2'd3) begin
                    shadow_ld = 1'b1;
                    if (rnd == 4'd1) fsm_n = FINAL;
                    else             rnd_n = rnd - 4'd1;
                end
            end
            FINAL: begin
                wr_en   = 1'b1;
                wr_word = ark_col;
                col_n   = col + 2'd1;
                if (col == 2'd3) begin
                    fsm_n  = OUT;
                    done_n = 1'b1;
                    dout_n = state[0];
                end
            end
            OUT: begin
                col_n = col + 2'd1;
                if (col == 2'd3) begin
                    fsm_n = IDLE;
                    rnd_n = 4'd9;
                end else begin
                    done_n = 1'b1;
                    dout_n = state[col_n];
                end
            end
            default: fsm_n = IDLE;
        endcase
        case (fsm_n)
            LOAD:    key_addr_n = 6'd40 + {4'd0, col_n};
            ROUND:   key_addr_n = {rnd_n, col_n};
            FINAL:   key_addr_n = {4'd0, col_n};
            default: key_addr_n = 6'd40;
        endcase
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            col      <= 2'd0;
            rnd      <= 4'd9;
            key_addr <= 6'd40;
            done     <= 1'b0;
            dout     <= 32'd0;
        end else begin
            fsm      <= fsm_n;
            col      <= col_n;
            rnd      <= rnd_n;
            key_addr <= key_addr_n;
            done     <= done_n;
            dout     <= dout_n;
        end
    end

    // State columns; the shadow snapshots the state as it will be at the start of the next pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                state[i]  <= 32'd0;
                shadow[i] <= 32'd0;
            end
        end else begin
            if (wr_en) state[col] <= wr_word;
            if (shadow_ld) begin
                for (int i = 0; i < 4; i++) shadow[i] <= (2'(i) == col) ? wr_word : state[i];
            end
        end
    end

    assign bus.key_addr = key_addr;
    assign bus.busy     = (fsm != IDLE);
    assign bus.done     = done;
    assign bus.dout     = dout;
endmodule

// File: tb/tb_aes32_dec_1p.sv
// tb/tb_aes32_dec_1p.sv - scoreboard bench for aes32_dec_1p with FIPS-197 vectors
module tb_aes32_dec_1p;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes32_dec_1p_if bus();
    aes32_dec_1p dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } exp_t;

    exp_t        sbq [$];
    exp_t        mon_e;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sbox [0:255];
    logic [31:0] ks [0:1][0:43];
    bit          kidx = 1'b0;

    // Vector 0: FIPS-197 C.1, vector 1: FIPS-197 appendix B.
    logic [127:0] keyv [0:1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    logic [127:0] ctv  [0:1] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h3925841d02dc09fbdc118597196a0b32};
    logic [127:0] ptv  [0:1] = '{128'h00112233445566778899aabbccddeeff, 128'h3243f6a8885a308d313198a2e0370734};

    // Asynchronous-read key RAM.
    assign bus.key = (bus.key_addr < 6'd44) ? ks[kidx][bus.key_addr] : 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [5:0] exp_ka(input int t);
        if (t == 0)  return 6'd40;
        if (t <= 3)  return 6'(40 + t);
        if (t <= 39) return 6'(4 * (9 - (t - 4) / 4) + (t - 4) % 4);
        if (t <= 43) return 6'(t - 40);
        return 6'd40;
    endfunction

    // Scoreboard monitor: every DONE cycle pops one expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", {31'd0, bus.done}, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("dout", bus.dout, mon_e.word);
                    chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end else begin
                chk("dout_zero_when_idle", bus.dout, 32'd0);
            end
        end
    end

    // Issue one block in the current cycle (DUT idle) and run it for 48 cycles.
    task automatic block(input bit v, input bit hold, input bit trace,
                         input int pulse_a, input int pulse_b, input int rst_at);
        int n;
        n = cyc;
        kidx      = v;
        bus.start = 1'b1;
        bus.din   = ctv[v][127:96];
        for (int w = 0; w < 4; w++) sbq.push_back('{word: ptv[v][127-32*w -: 32], cyc: n + 44 + w});
        if (trace) begin
            chk("key_addr_t0", {26'd0, bus.key_addr}, {26'd0, exp_ka(0)});
            chk("busy_t0", {31'd0, bus.busy}, 32'd0);
        end
        for (int t = 1; t < 48; t++) begin
            tick();
            bus.din   = (t <= 3) ? ctv[v][127-32*t -: 32] : $urandom;
            bus.start = hold || (t == pulse_a) || (t == pulse_b);
            if (trace) begin
                chk("key_addr", {26'd0, bus.key_addr}, {26'd0, exp_ka(t)});
                chk("busy", {31'd0, bus.busy}, 32'd1);
            end
            if (t == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_key_addr", {26'd0, bus.key_addr}, 32'd40);
                chk("rst_busy", {31'd0, bus.busy}, 32'd0);
                chk("rst_done", {31'd0, bus.done}, 32'd0);
                chk("rst_dout", bus.dout, 32'd0);
                sbq.delete();
                bus.start = 1'b0;
                repeat (2) tick();
                rst_n = 1'b1;
                tick();
                return;
            end
        end
        tick();
        bus.start = hold;
        chk("busy_t48", {31'd0, bus.busy}, 32'd0);
        chk("key_addr_t48", {26'd0, bus.key_addr}, 32'd40);
    endtask

    initial begin
        logic [7:0]  inv;
        logic [7:0]  rc;
        logic [31:0] tmp;
        bus.start = 1'b0;
        bus.din   = 32'd0;

        // Forward S-box from GF(2^8) inverse plus affine map, then key expansion.
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int v = 0; v < 2; v++) begin
            rc = 8'h01;
            for (int i = 0; i < 4; i++) ks[v][i] = keyv[v][127-32*i -: 32];
            for (int i = 4; i < 44; i++) begin
                tmp = ks[v][i-1];
                if (i % 4 == 0) begin
                    tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                    rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end
                ks[v][i] = ks[v][i-4] ^ tmp;
            end
        end

        repeat (3) tick();
        chk("reset_key_addr", {26'd0, bus.key_addr}, 32'd40);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_dout", bus.dout, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        block(1'b0, 1'b0, 1'b1, -1, -1, -1);
        block(1'b1, 1'b0, 1'b0, 10, 47, -1);
        repeat (12) tick();
        chk("idle_after_ignored_starts", {31'd0, bus.busy}, 32'd0);
        block(1'b0, 1'b0, 1'b0, -1, -1, 20);
        repeat (5) tick();
        chk("idle_after_abort", {31'd0, bus.busy}, 32'd0);
        block(1'b0, 1'b0, 1'b0, -1, -1, -1);
        repeat (3) tick();
        block(1'b0, 1'b1, 1'b0, -1, -1, -1);
        block(1'b1, 1'b1, 1'b0, -1, -1, -1);
        block(1'b0, 1'b0, 1'b0, -1, -1, -1);

        for (int i = 0; i < 100 && sbq.size() != 0; i++) tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        repeat (10) tick();
        chk("final_idle", {31'd0, bus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes32_dec_1p.md
AES32_DEC_1P -- requirements
Module: aes32_dec_1p

Interface
REQ-001 The block SHALL have no parameters; it is fixed to AES-128 decryption on a 32-bit datapath, one block in flight.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset; asserting it clears all state immediately, and release is sampled on CLK.
REQ-004 START  input  1  request; sampled only when BUSY is low; word 0 of the ciphertext is on DIN in the same cycle.
REQ-005 DIN  input  32  ciphertext word; word w carries bytes 4w..4w+3, with byte 4w in bits [31:24].
REQ-006 KEY  input  32  expanded-key word w[KEY_ADDR] (FIPS-197 numbering 0..43); must be valid in the same cycle KEY_ADDR is driven (asynchronous-read key RAM).
REQ-007 KEY_ADDR  output  6  registered index of the key word consumed this cycle.
REQ-008 BUSY  output  1  high from the cycle after START acceptance through the last DONE cycle.
REQ-009 DONE  output  1  high for exactly 4 consecutive cycles while plaintext words 0..3 are presented.
REQ-010 DOUT  output  32  plaintext word; it SHALL be 32'd0 whenever DONE is low.

Function
REQ-011 States SHALL be IDLE, LOAD, ROUND, FINAL and OUT. A 2-bit column counter col SHALL run 0..3 in every state except IDLE. A 4-bit round counter rnd SHALL run 9 down to 1.
REQ-012 IDLE: KEY_ADDR=40. When START=1: state[col0] <= DIN ^ KEY, col <= 1, go to LOAD. START=0 leaves the block in IDLE.
REQ-013 LOAD (3 cycles): KEY_ADDR = 40+col; state[col] <= DIN ^ KEY. After col 3, set rnd=9 and col=0 and go to ROUND. DIN is ignored outside IDLE/LOAD.
REQ-014 At entry to each ROUND or FINAL pass, the 128-bit state SHALL be copied to a shadow register; all four columns of the pass read only the shadow.
REQ-015 ROUND (4 cycles per round): KEY_ADDR = 4*rnd+col. New column col = InvMixColumns(InvSubBytes(InvShiftRows(shadow))[col] ^ KEY).
REQ-016 InvShiftRows rule: row r of column c is taken from shadow column (c-r) mod 4. Row 0 is bits [31:24].
REQ-017 After column 3 of a round: if rnd=1, go to FINAL; else decrement rnd. In both cases col wraps to 0.
REQ-018 FINAL (4 cycles): KEY_ADDR = col (0..3). Column = InvSubBytes(InvShiftRows(shadow))[col] ^ KEY, with no InvMixColumns. After col 3, go to OUT.
REQ-019 InvSubBytes SHALL be the FIPS-197 inverse S-box, either as a combinational table or as a GF(2^8) inverse plus inverse affine map. Latency SHALL remain one cycle per column.
REQ-020 InvMixColumns SHALL use coefficients {0e,0b,0d,09} over GF(2^8) with reduction polynomial 0x11B.
REQ-021 OUT (4 cycles): DONE=1 and DOUT = state word col, for col 0..3. DONE and DOUT SHALL be registered. Return to IDLE after col 3.
REQ-022 Latency: with START accepted in cycle 0, the cycles are:
- LOAD: 1-3
- ROUND: 4-39
- FINAL: 40-43
- DONE: 44-47
- IDLE, able to accept START: 48
REQ-023 Throughput SHALL be one block per 48 cycles.
REQ-024 START asserted while BUSY=1 SHALL be ignored with no effect on the block in flight.
REQ-025 KEY is sampled only in IDLE-with-START, LOAD, ROUND and FINAL. In OUT, KEY_ADDR SHALL hold 40 and KEY is ignored.
REQ-026 Back-to-back: START held high continuously SHALL start a new block in cycle 48, then every 48 cycles thereafter.

Reset
REQ-027 While RST_N=0 the block SHALL hold: state=IDLE, col=0, rnd=9, KEY_ADDR=40, BUSY=0, DONE=0, DOUT=0, state and shadow registers=0.
REQ-028 Reset asserted mid-operation SHALL abort the block. No DONE pulse is produced for the aborted block, and the first START after release SHALL decrypt correctly.

Verification
REQ-029 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, CT 69c4e0d86a7b0430d8cdb78070b4c55a -> DOUT 00112233,44556677,8899aabb,ccddeeff in cycles 44-47.
REQ-030 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, CT 3925841d02dc09fbdc118597196a0b32 -> PT 3243f6a8885a308d313198a2e0370734.
REQ-031 KEY_ADDR trace: IDLE/START cycle gives 40, then 41,42,43,36..39,32..35,...,4..7,0,1,2,3, then 40 throughout OUT.
REQ-032 START pulsed in cycles 10 and 47 after an accepted START: both ignored, and exactly one 4-cycle DONE burst occurs.
REQ-033 RST_N pulsed low at cycle 20 of a block: all outputs clear immediately and DONE is never asserted. Re-running the C.1 vector then passes.
REQ-034 START held high for 3 blocks using the C.1 and B vectors alternately: DONE bursts at cycles 44, 92 and 140, with correct plaintexts; DOUT=0 outside the bursts.
